// File: rtl/exp_accum.sv
// Frame accumulator for exp() samples: sums up to ACC_LEN beats (or until tlast) and emits sum + count one cycle after the closing beat.
// Input tready drops while the result waits for downstream. Build option EXP_ACC_SAT_EN saturates tdata on overflow; otherwise it wraps.
module exp_accum #(
  parameter int ACC_LEN = 16,
  parameter int ACC_W   = 48
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [31:0] s_axis_data_tdata,
  input  logic        s_axis_data_tvalid,
  input  logic        s_axis_data_tlast,
  output logic        s_axis_data_tready,
  output logic [31:0] m_axis_data_tdata,
  output logic [16:0] m_axis_data_tuser,
  output logic        m_axis_data_tvalid,
  input  logic        m_axis_data_tready
);

  typedef enum logic [1:0] {IDLE, ACCUM, OUTPUT} state_t;

  localparam logic [15:0] LEN = ACC_LEN[15:0];

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [15:0]        cnt_q, cnt_d;
  logic [31:0]        tdata_q, tdata_d;
  logic [16:0]        tuser_q, tuser_d;

  logic               beat;
  logic [ACC_W-1:0]   sext;
  logic [ACC_W-1:0]   acc_sum;
  logic [15:0]        cnt_sum;
  logic               close;
  logic               ovf;
  logic [31:0]        res_dat;

  assign s_axis_data_tready = (state_q != OUTPUT);
  assign m_axis_data_tvalid = (state_q == OUTPUT);
  assign m_axis_data_tdata  = tdata_q;
  assign m_axis_data_tuser  = tuser_q;

  assign beat    = s_axis_data_tvalid && s_axis_data_tready;
  assign sext    = {{(ACC_W-32){s_axis_data_tdata[31]}}, s_axis_data_tdata};
  assign acc_sum = (state_q == IDLE) ? sext : acc_q + sext;
  assign cnt_sum = (state_q == IDLE) ? 16'd1 : cnt_q + 16'd1;
  assign close   = (cnt_sum == LEN) || s_axis_data_tlast;

  // In range iff every bit from 31 upward matches the sign.
  assign ovf = !((&acc_sum[ACC_W-1:31]) || !(|acc_sum[ACC_W-1:31]));

`ifdef EXP_ACC_SAT_EN
  assign res_dat = ovf ? (acc_sum[ACC_W-1] ? 32'h8000_0000 : 32'h7FFF_FFFF) : acc_sum[31:0];
`else
  assign res_dat = acc_sum[31:0];
`endif

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      tdata_q <= '0;
      tuser_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      tdata_q <= tdata_d;
      tuser_q <= tuser_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    tdata_d = tdata_q;
    tuser_d = tuser_q;
    case (state_q)
      IDLE, ACCUM: begin
        if (beat) begin
          acc_d = acc_sum;
          cnt_d = cnt_sum;
          if (close) begin
            state_d = OUTPUT;
            tdata_d = res_dat;
            tuser_d = {ovf, cnt_sum};
          end else begin
            state_d = ACCUM;
          end
        end
      end
      OUTPUT: begin
        if (m_axis_data_tready) begin
          acc_d   = '0;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: doc/exp_accum.md
# exp_accum

Frame accumulator directly downstream of the Taylor-series `exp` block in the HSS datapath. It consumes the AXI-Stream of fixed-point exp(x) results and sums a frame of samples into a wide signed accumulator. A frame ends after `ACC_LEN` accepted beats or on an early `s_axis_data_tlast`. It then emits one beat carrying the frame sum and its sample count, which the normalisation stage uses as the partition sum.

## Interface
- `ACC_LEN`, 16, samples per full frame; legal range 1..65535.
- `ACC_W`, 48, internal accumulator width in bits; must be ≥ 33.
- `aclk`  in  1  clock.
- `aresetn`  in  1  reset, synchronous, active-low; clock `aclk`.
- `s_axis_data_tdata`  in  32  signed exp sample, same fixed-point format as the `exp` output.
- `s_axis_data_tvalid`  in  1  input beat valid.
- `s_axis_data_tlast`  in  1  early end-of-frame marker.
- `s_axis_data_tready`  out  1  block can accept a beat.
- `m_axis_data_tdata`  out  32  signed frame sum, same fixed-point format as the input.
- `m_axis_data_tuser`  out  17  bit 16 = sum overflowed 32 bits; bits 15:0 = sample count.
- `m_axis_data_tvalid`  out  1  result valid.
- `m_axis_data_tready`  in  1  downstream accepts the result.

## Operation
- FSM states: IDLE, ACCUM, OUTPUT.
- Accepted beat: `s_axis_data_tvalid && s_axis_data_tready`.
- In IDLE and ACCUM, `s_axis_data_tready` = 1. In OUTPUT it is 0.
- IDLE, on an accepted beat:
  - acc ← sign-extended `s_axis_data_tdata`; cnt ← 1.
  - Go to ACCUM, or go straight to OUTPUT if `tlast` = 1 or `ACC_LEN` = 1.
- ACCUM, on an accepted beat:
  - acc ← acc + sign-extended data; cnt ← cnt + 1.
  - If the new cnt == `ACC_LEN` or `tlast` = 1, go to OUTPUT.
  - Cycles with no accepted beat hold acc and cnt unchanged.
- OUTPUT:
  - `m_axis_data_tvalid` = 1. tdata and tuser are registered and stay stable until the handshake.
  - On `m_axis_data_tvalid && m_axis_data_tready`: acc ← 0, cnt ← 0, go to IDLE.
- `tlast` is ignored on a beat that already completes an `ACC_LEN` frame; the frame simply closes.
- Arithmetic:
  - Two's-complement addition at `ACC_W` bits; no rescaling, because sums stay in the input format.
  - Overflow flag (`tuser[16]`) = 1 when the final acc lies outside [−2^31, 2^31−1].
- Negative inputs are accepted and summed unchanged.

## Timing
- Reset values:
  - `s_axis_data_tready` = 1 (the block is ready in the first cycle after reset).
  - `m_axis_data_tvalid` = 0, `m_axis_data_tdata` = 0, `m_axis_data_tuser` = 0.
  - FSM = IDLE, acc = 0, cnt = 0.
- Latency: `m_axis_data_tvalid` rises on the clock edge that accepts the frame-closing beat, i.e. visible in the next cycle.
- Throughput: one input beat per cycle inside a frame, plus one bubble cycle per frame (the OUTPUT cycle) at minimum.
- Back-pressure: while `m_axis_data_tready` = 0 in OUTPUT, the block stalls and input tready stays 0; no input is lost.
- Reset mid-frame or mid-OUTPUT: the partial sum and any pending result are discarded, with no output beat. All outputs return to their reset values on the next edge.
- `s_axis_data_tvalid` may drop between beats without affecting the frame.

## Configuration
- Macro: `EXP_ACC_SAT_EN`.
- Defined: `m_axis_data_tdata` saturates to 32'h7FFFFFFF (positive overflow) or 32'h80000000 (negative overflow).
- Undefined: `m_axis_data_tdata` = acc[31:0], i.e. wraps.
- `tuser[16]` reports overflow in both builds.

## Test plan
- Full frame: `ACC_LEN`=16, 16 beats of 0x00001000 (1.0), m_tready=1 → one result, tdata=0x00010000, tuser=0x00010; s_tready=0 for exactly one cycle.
- Early tlast: 5 beats of 0x00000800 with tlast on beat 5 → tdata=0x00002800, tuser=0x00005; the next frame starts with cnt=1.
- Back-pressure: hold m_tready=0 for 10 cycles after the frame closes → tdata/tuser/tvalid stable and s_tready=0 throughout; handshake on release, s_tready=1 in the next cycle.
- Overflow: 4 beats of 0x7FFFFFFF → tuser[16]=1; tdata=0x7FFFFFFF with `EXP_ACC_SAT_EN`, 0xFFFFFFFC without.
- Reset mid-frame: 7 beats accepted, then aresetn=0 for 1 cycle, then a full 16-beat frame of 0x00001000 → only one output, tdata=0x00010000, count 16.
- Gapped input: 16 beats of 0x00000001 with tvalid toggling every cycle → tdata=0x00000010, tuser=0x00010.
